// File: rtl/pcint0_ctrl_pkg.sv
// Shared constants and state type for the Port B pin-change interrupt controller.
package pcint0_ctrl_pkg;

  localparam logic [5:0] PCIFR_IO_ADDR_DEF   = 6'h1B;
  localparam logic [7:0] PCICR_RAM_ADDR_DEF  = 8'h68;
  localparam logic [7:0] PCMSK0_RAM_ADDR_DEF = 8'h6B;

  localparam int unsigned PCIF0_BIT = 0;
  localparam int unsigned PCIE0_BIT = 0;

  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    WARM2 = 2'd2,
    ARMED = 2'd3
  } arm_state_e;

endpackage

// File: rtl/pcint0_ctrl_sync_edge.sv
// Port B input synchroniser, optional two-sample filter (PCINT0_FILTER_EN) and
// previous-value register; outputs the unmasked per-pin change vector.
module pcint_sync_edge (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [7:0] pin_i,
  input  logic       prime_i,
  output logic [7:0] change_o
);

  logic [7:0] s1_q, s2_q, prev_q, prev_d;

`ifdef PCINT0_FILTER_EN
  logic [7:0] s3_q;
  logic [7:0] stable;

  assign stable = ~(s2_q ^ s3_q);

  // While priming, prev is loaded from the stage feeding the last compared one so
  // that it already matches the filled pipeline when the arming FSM lets edges through.
  always_comb begin
    prev_d   = prime_i ? s2_q : ((stable & s2_q) | (~stable & prev_q));
    change_o = stable & (s2_q ^ prev_q);
  end

  always_ff @(posedge cp2) begin
    if (ireset) s3_q <= '0;
    else        s3_q <= s2_q;
  end
`else
  always_comb begin
    prev_d   = prime_i ? s1_q : s2_q;
    change_o = s2_q ^ prev_q;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the synchroniser.
  always_ff @(posedge cp2) begin
    if (ireset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= pin_i;
      s2_q   <= s1_q;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/pcint0_ctrl.sv
// PCINT group 0 controller: PCMSK0/PCICR/PCIFR registers, arming FSM, flag and irq.
// Optional input filter selected by defining PCINT0_FILTER_EN.
module pcint0_ctrl
  import pcint0_ctrl_pkg::*;
#(
  parameter logic [5:0] PCIFR_IO_ADDR   = PCIFR_IO_ADDR_DEF,
  parameter logic [7:0] PCICR_RAM_ADDR  = PCICR_RAM_ADDR_DEF,
  parameter logic [7:0] PCMSK0_RAM_ADDR = PCMSK0_RAM_ADDR_DEF
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [5:0] IO_Addr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       out_en,
  input  logic [7:0] pin_i,
  output logic [7:0] PCINT_o,
  output logic       PCIE0_o,
  output logic       irq,
  input  logic       irq_ack
);

  arm_state_e state_q, state_d;
  logic [7:0] pcmsk_q, pcmsk_d;
  logic       pcie0_q, pcie0_d;
  logic       pcif0_q, pcif0_d;
  logic       armed;
  logic [7:0] change, edges;
  logic       pcifr_rd, pcifr_wr, pcicr_rd, pcicr_wr, pcmsk_rd, pcmsk_wr;

  assign pcifr_rd = iore  & (IO_Addr == PCIFR_IO_ADDR);
  assign pcifr_wr = iowe  & (IO_Addr == PCIFR_IO_ADDR);
  assign pcicr_rd = ramre & (ramadr  == PCICR_RAM_ADDR);
  assign pcicr_wr = ramwe & (ramadr  == PCICR_RAM_ADDR);
  assign pcmsk_rd = ramre & (ramadr  == PCMSK0_RAM_ADDR);
  assign pcmsk_wr = ramwe & (ramadr  == PCMSK0_RAM_ADDR);

  assign armed = (state_q == ARMED);

  pcint_sync_edge u_sync_edge (
    .cp2      (cp2),
    .ireset   (ireset),
    .pin_i    (pin_i),
    .prime_i  (~armed),
    .change_o (change)
  );

  assign edges = change & pcmsk_q & {8{armed}};

  // NOTE: every signal written here is given a default first, so no path through
  // the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WARM0: state_d = WARM1;
`ifdef PCINT0_FILTER_EN
      WARM1: state_d = WARM2;
`else
      WARM1: state_d = ARMED;
`endif
      WARM2: state_d = ARMED;
      ARMED: state_d = ARMED;
      default: state_d = WARM0;
    endcase
  end

  always_comb begin
    pcmsk_d = pcmsk_wr ? dbus_in : pcmsk_q;
    pcie0_d = pcicr_wr ? dbus_in[PCIE0_BIT] : pcie0_q;
    pcif0_d = pcif0_q;
    if ((pcifr_wr & dbus_in[PCIF0_BIT]) | (irq_ack & irq)) pcif0_d = 1'b0;
    // A new edge outranks any clear in the same cycle so it is never lost.
    if (|edges) pcif0_d = 1'b1;
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      state_q <= WARM0;
      pcmsk_q <= '0;
      pcie0_q <= 1'b0;
      pcif0_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcmsk_q <= pcmsk_d;
      pcie0_q <= pcie0_d;
      pcif0_q <= pcif0_d;
    end
  end

  always_comb begin
    dbus_out = '0;
    if (pcifr_rd)      dbus_out[PCIF0_BIT] = pcif0_q;
    else if (pcicr_rd) dbus_out[PCIE0_BIT] = pcie0_q;
    else if (pcmsk_rd) dbus_out            = pcmsk_q;
  end

  assign out_en  = pcifr_rd | pcicr_rd | pcmsk_rd;
  assign irq     = pcif0_q & pcie0_q;
  assign PCINT_o = pcmsk_q;
  assign PCIE0_o = pcie0_q;

endmodule
